byte_serial_adder: RTL and testbench
====================================

Name: byte_serial_adder

Overview:
- Sequencer that adds two NBYTES-wide operands one byte per clock.
- Reuses the team's 8-bit ripple-carry adder (rca_8) as its datapath and chains the carry through a register between bytes.
- Sits directly around rca_8: feeds it byte operands and a carry-in, and consumes its sum and carry-out.
- Provides wide addition at 8-bit adder area cost, with a valid/ready handshake on both sides.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand; legal range 1..16.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and cin are valid.
- in_ready  out  1  block can accept an operation.
- a  in  8*NBYTES  operand A, unsigned or two's complement.
- b  in  8*NBYTES  operand B.
- cin  in  1  carry into byte 0.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  8*NBYTES  (a + b + cin) mod 2^(8*NBYTES).
- cout  out  1  carry out of the MSB.
- overflow  out  1  signed overflow.

Behaviour:
- Reset values while rst=1 at an edge:
  - state=IDLE.
  - in_ready=1 after reset.
  - out_valid=0, sum=0, cout=0, overflow=0.
  - Internal carry register, byte index and operand registers cleared.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b; carry_q<=cin; idx<=0; go to RUN.
  - Inputs are not sampled again until the next acceptance.
- State RUN:
  - in_ready=0.
  - Each cycle rca_8 receives a_q[8*idx+:8], b_q[8*idx+:8] and carry_q.
  - Its s is written to sum_q[8*idx+:8]; carry_q<=its cout; idx<=idx+1.
  - When idx==NBYTES-1, go to DONE on that same edge.
- State DONE:
  - out_valid=1.
  - sum, cout (=carry_q) and overflow are registered and stable.
  - overflow = (a_q[MSB]==b_q[MSB]) && (sum_q[MSB]!=a_q[MSB]).
  - Outputs hold while out_ready=0; in_ready=0.
  - On out_ready=1: go to IDLE. out_valid drops next cycle; sum/cout/overflow keep their last value until overwritten.
- Latency and throughput:
  - Accept edge at cycle T; out_valid is high from cycle T+NBYTES+1.
  - Throughput is one operation per NBYTES+2 cycles with out_ready tied high.
- No overlap: a new operation cannot be accepted in the DONE cycle.
- NBYTES=1: RUN lasts exactly one cycle.
- in_valid while busy is ignored; the producer must hold in_valid until in_ready.
- Reset mid-operation (RUN or DONE):
  - The in-flight operation is discarded with no out_valid pulse.
  - Outputs return to reset values; IDLE on the next cycle.
- X-safety: a and b are don't-care outside the accept cycle.

Decomposition:
- Shared package holds:
  - BYTE_W=8.
  - State enum {IDLE, RUN, DONE} (2-bit encoding).
  - Index width function clog2(NBYTES), minimum 1.
- One sub-module: rca_8 (existing 8-bit ripple-carry adder), instantiated once as the datapath.
- FSM, index counter, operand/sum registers and carry flop stay in byte_serial_adder.

Test Plan:
1. NBYTES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> out_valid 5 cycles after accept; sum=0x00000000, cout=1, overflow=0.
2. NBYTES=4, a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1.
3. NBYTES=4, a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0, overflow=0.
4. Back-pressure: test 3 with out_ready=0 for 3 cycles after out_valid:
   - sum/out_valid held stable, in_ready=0 throughout.
   - out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
   - A second operation 0x1+0x1 then yields 0x00000002.
5. Reset mid-op: accept 0xFFFFFFFF+0x1, assert rst in the 2nd RUN cycle:
   - out_valid never rises.
   - sum=0, cout=0, in_ready=1 after rst deasserts.
   - A following 0x5+0x3 yields 0x00000008.
6. NBYTES=1, a=0x80, b=0x80, cin=0 -> out_valid 2 cycles after accept; sum=0x00, cout=1, overflow=1.

Source files
------------

// File: rtl/byte_serial_adder_pkg.sv
// Shared definitions for the byte-serial adder: byte width, FSM encoding and
// the byte-index width helper.
package byte_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index must hold 0..n-1; a single byte still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/byte_serial_adder_rca_8.sv
// 8-bit ripple-carry adder used as the shared datapath of the byte-serial adder.
module rca_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < 8; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[8];

endmodule

// File: rtl/byte_serial_adder.sv
// Adds two NBYTES-wide operands one byte per clock through a single rca_8,
// carrying between bytes in a register. valid/ready handshake on both sides.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BYTE_W*NBYTES-1:0]   a,
  input  logic [BYTE_W*NBYTES-1:0]   b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W*NBYTES-1:0]   sum,
  output logic                       cout,
  output logic                       overflow,
  output logic [1:0]                 dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its data until that edge, ready may depend
  // on state only, never combinationally on valid.

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [BYTE_W-1:0]  rca_a, rca_b, rca_s;
  logic               rca_cout;

  assign rca_a = a_q[BYTE_W*idx_q +: BYTE_W];
  assign rca_b = b_q[BYTE_W*idx_q +: BYTE_W];

  rca_8 u_rca (
    .a_i    (rca_a),
    .b_i    (rca_b),
    .cin_i  (carry_q),
    .s_o    (rca_s),
    .cout_o (rca_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    dbg_state_o = state_q;
  end

  // cout/overflow are captured on the final byte so they stay stable in DONE
  // and after, independent of carry_q being reloaded on the next accept.
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[BYTE_W*idx_q +: BYTE_W] = rca_s;
        carry_d = rca_cout;
        if (idx_q == LAST) begin
          idx_d  = '0;
          cout_d = rca_cout;
          ovf_d  = (a_q[W-1] == b_q[W-1]) && (rca_s[BYTE_W-1] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed tests for byte_serial_adder: a 4-byte instance for the main
// scenarios and a 1-byte instance for the single-byte corner.
module tb_byte_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, overflow;
  logic [31:0] a, b, sum;
  logic [1:0]  dbg4;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, overflow1;
  logic [7:0]  a1, b1, sum1;
  logic [1:0]  dbg1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  byte_serial_adder #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .dbg_state_o(dbg4)
  );

  byte_serial_adder #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .overflow(overflow1), .dbg_state_o(dbg1)
  );

  // Drive one operation into dut4; lat counts sampling points from the accept
  // edge until out_valid is seen (20 means it never arrived).
  task automatic op4(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                     output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", sum); end
    total++; if ({cout, overflow} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf got=%b exp=00", {cout, overflow}); end
    total++; if (dbg4 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg4); end
  endtask

  task automatic test_carry_wrap();
    int lat;
    op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL wrap_latency got=%0d exp=5", lat); end
    total++; if (sum !== 32'h0000_0000) begin bad++; $display("FAIL wrap_sum got=%h exp=00000000", sum); end
    total++; if ({cout, overflow} !== 2'b10) begin bad++; $display("FAIL wrap_cout_ovf got=%b exp=10", {cout, overflow}); end
    total++; if (dbg4 !== 2'd2) begin bad++; $display("FAIL wrap_state got=%0d exp=2", dbg4); end
    @(negedge clk);
  endtask

  task automatic test_signed_overflow();
    int lat;
    op4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL ovf_latency got=%0d exp=5", lat); end
    total++; if (sum !== 32'h8000_0000) begin bad++; $display("FAIL ovf_sum got=%h exp=80000000", sum); end
    total++; if ({cout, overflow} !== 2'b01) begin bad++; $display("FAIL ovf_cout_ovf got=%b exp=01", {cout, overflow}); end
    @(negedge clk);
  endtask

  task automatic test_cin();
    int lat;
    op4(32'h1234_5678, 32'h1111_1111, 1'b1, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL cin_latency got=%0d exp=5", lat); end
    total++; if (sum !== 32'h2345_678A) begin bad++; $display("FAIL cin_sum got=%h exp=2345678a", sum); end
    total++; if ({cout, overflow} !== 2'b00) begin bad++; $display("FAIL cin_cout_ovf got=%b exp=00", {cout, overflow}); end
    @(negedge clk);
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL cin_release got=%b exp=01", {out_valid, in_ready}); end
    total++; if (sum !== 32'h2345_678A) begin bad++; $display("FAIL cin_sum_hold got=%h exp=2345678a", sum); end
  endtask

  task automatic test_back_pressure();
    int lat;
    out_ready = 1'b0;
    op4(32'h1234_5678, 32'h1111_1111, 1'b1, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    // a competing request during DONE must be ignored
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold_hs[%0d] got=%b exp=10", i, {out_valid, in_ready}); end
      total++; if (sum !== 32'h2345_678A) begin bad++; $display("FAIL bp_hold_sum[%0d] got=%h exp=2345678a", i, sum); end
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready}); end
    op4(32'h0000_0001, 32'h0000_0001, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL bp2_latency got=%0d exp=5", lat); end
    total++; if (sum !== 32'h0000_0002) begin bad++; $display("FAIL bp2_sum got=%h exp=00000002", sum); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    @(negedge clk);                 // first RUN cycle
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_run1_valid got=%b exp=0", out_valid); end
    @(negedge clk);                 // second RUN cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL rmid_hs got=%b exp=01", {out_valid, in_ready}); end
    total++; if (sum !== 32'h0) begin bad++; $display("FAIL rmid_sum got=%h exp=0", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL rmid_cout got=%b exp=0", cout); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_valid[%0d] got=%b exp=0", i, out_valid); end
    end
    op4(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL rmid2_latency got=%0d exp=5", lat); end
    total++; if (sum !== 32'h0000_0008) begin bad++; $display("FAIL rmid2_sum got=%h exp=00000008", sum); end
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int lat;
    @(negedge clk);
    in_valid1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0; a1 = 8'h3C; b1 = 8'hA5;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid1) break;
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL nb1_latency got=%0d exp=2", lat); end
    total++; if (sum1 !== 8'h00) begin bad++; $display("FAIL nb1_sum got=%h exp=00", sum1); end
    total++; if ({cout1, overflow1} !== 2'b11) begin bad++; $display("FAIL nb1_cout_ovf got=%b exp=11", {cout1, overflow1}); end
    @(negedge clk);
    total++; if ({out_valid1, in_ready1} !== 2'b01) begin bad++; $display("FAIL nb1_release got=%b exp=01", {out_valid1, in_ready1}); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_carry_wrap();
    test_signed_overflow();
    test_cin();
    test_back_pressure();
    test_reset_mid_op();
    test_single_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
